// File: rtl/pwm_stream_dac.sv
// Streamed 8-bit PCM to single-pin PWM, one 256-step period per sample.
// Small FIFO decouples fetch timing; empty FIFO at a period end plays SILENCE.
module pwm_stream_dac #(
   parameter int         PRESCALE    = 26,
   parameter int         FIFO_DEPTH  = 4,
   parameter int         PRIME_LEVEL = 2,
   parameter logic [7:0] SILENCE     = 8'h80
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       enable,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   output logic       audio_out,
   output logic       busy,
   output logic       underrun
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] PRIME_C = CW'(PRIME_LEVEL);
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      PLAY
   } state_t;

   state_t        state;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [PW-1:0] prescaler;
   logic [7:0]    counter;
   logic [7:0]    cur_sample;
   logic          push;
   logic          pop;
   logic          tick;
   logic          swap;
   logic          start;

   assign s_ready = (count != FULL);

   always_comb begin
      push  = s_valid && s_ready;
      tick  = (state == PLAY) && (prescaler == PS_LAST);
      swap  = tick && enable && (counter == 8'hFF);
      start = (state == PRIME) && enable && (count >= PRIME_C);
      pop   = start || (swap && (count != '0));
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= s_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state      <= IDLE;
         prescaler  <= '0;
         counter    <= '0;
         cur_sample <= SILENCE;
         audio_out  <= 1'b0;
         busy       <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         underrun <= 1'b0;
         unique case (state)
            IDLE: begin
               audio_out <= 1'b0;
               prescaler <= '0;
               counter   <= '0;
               if (enable) begin
                  state <= PRIME;
                  busy  <= 1'b1;
               end
            end
            PRIME: begin
               audio_out <= 1'b0;
               if (!enable) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (start) begin
                  state      <= PLAY;
                  cur_sample <= mem[rd_ptr];
                  counter    <= '0;
                  prescaler  <= '0;
               end
            end
            PLAY: begin
               if (!enable) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  audio_out  <= 1'b0;
                  prescaler  <= '0;
                  counter    <= '0;
                  cur_sample <= SILENCE;
               end else begin
                  prescaler <= tick ? '0 : prescaler + PW'(1);
                  if (tick) begin
                     // compare uses the outgoing sample even on the swap tick
                     audio_out <= (cur_sample > counter);
                     counter   <= counter + 8'd1;
                     if (counter == 8'hFF) begin
                        if (count != '0) begin
                           cur_sample <= mem[rd_ptr];
                        end else begin
                           cur_sample <= SILENCE;
                           underrun   <= 1'b1;
                        end
                     end
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_stream_dac.sv
// Directed bench for pwm_stream_dac: duty table plus hand-timed
// priming, underrun, push/pop, stop/resume and reset sequences.
module tb_pwm_stream_dac;

   localparam int PS  = 2;
   localparam int PER = 256 * PS;
   localparam int HN  = 4608;

   logic       CLK     = 1'b0;
   logic       RST_N   = 1'b0;
   logic       enable  = 1'b0;
   logic [7:0] s_data  = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic       audio_out;
   logic       busy;
   logic       underrun;

   pwm_stream_dac #(
      .PRESCALE   (PS),
      .FIFO_DEPTH (4),
      .PRIME_LEVEL(2),
      .SILENCE    (8'h80)
   ) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .enable   (enable),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .audio_out(audio_out),
      .busy     (busy),
      .underrun (underrun)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] sample;
      int         steps;
   } vec_t;

   vec_t       tbl [8];
   int         n_vec = 0;
   int         n_bad = 0;
   int         cyc   = 0;
   bit         feed_en = 1'b0;
   logic [7:0] feed_q [$];
   logic       aud [0:HN-1];
   logic       ur  [0:HN-1];

   task automatic chk_b(input string nm, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // each step lands on a negedge; feeder offers data only when it will be taken
   task automatic step();
      @(negedge CLK);
      if (feed_en) begin
         if (feed_q.size() > 0 && s_ready) begin
            s_valid = 1'b1;
            s_data  = feed_q.pop_front();
         end else begin
            s_valid = 1'b0;
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         step();
         cyc++;
         if (cyc < HN) begin
            aud[cyc] = audio_out;
            ur[cyc]  = underrun;
         end
      end
   endtask

   task automatic mark();
      cyc = 0;
      for (int i = 0; i < HN; i++) begin
         aud[i] = 1'b0;
         ur[i]  = 1'b0;
      end
   endtask

   task automatic push_chk(input logic [7:0] v, input logic rdy,
                           input string nm);
      s_valid = 1'b1;
      s_data  = v;
      chk_b(nm, s_ready, rdy);
      step();
      s_valid = 1'b0;
   endtask

   function automatic int hi_cycles(input int k);
      int s = 0;
      int b = 4 + PER * (k - 1);
      for (int i = b; i < b + PER; i++) begin
         if (aud[i] === 1'b1) s++;
      end
      return s;
   endfunction

   function automatic int misaligned(input int k);
      int n = 0;
      int b = 4 + PER * (k - 1);
      for (int j = 0; j < PER / 2; j++) begin
         if (aud[b + 2*j] !== aud[b + 2*j + 1]) n++;
      end
      return n;
   endfunction

   function automatic int ur_count(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++) begin
         if (ur[i] === 1'b1) n++;
      end
      return n;
   endfunction

   function automatic int hi_range(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++) begin
         if (aud[i] === 1'b1) n++;
      end
      return n;
   endfunction

   initial begin
      tbl[0] = '{8'h40, 64};
      tbl[1] = '{8'hFF, 255};
      tbl[2] = '{8'h00, 0};
      tbl[3] = '{8'h80, 128};
      tbl[4] = '{8'h01, 1};
      tbl[5] = '{8'hFE, 254};
      tbl[6] = '{8'h7F, 127};
      tbl[7] = '{8'h20, 32};

      // reset and idle fill
      RST_N  = 1'b0;
      enable = 1'b0;
      repeat (3) step();
      RST_N = 1'b1;
      step();
      chk_b("rst_audio", audio_out, 1'b0);
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_ready", s_ready, 1'b1);
      chk_b("rst_underrun", underrun, 1'b0);
      for (int i = 0; i < 4; i++) begin
         push_chk(tbl[i].sample, 1'b1, $sformatf("fill_rdy%0d", i));
      end
      push_chk(8'h11, 1'b0, "fill_full");
      mark();
      run(10);
      chk_i("idle_quiet", hi_range(1, 10), 0);
      chk_b("idle_busy", busy, 1'b0);

      // duty table; later entries streamed in while playing
      for (int i = 4; i < 8; i++) feed_q.push_back(tbl[i].sample);
      feed_en = 1'b1;
      enable  = 1'b1;
      mark();
      run(1);
      chk_b("duty_busy", busy, 1'b1);
      run(4098);
      chk_b("duty_lat0", aud[3], 1'b0);
      chk_b("duty_lat1", aud[4], 1'b1);
      for (int k = 1; k <= 8; k++) begin
         chk_i($sformatf("duty_%02h", tbl[k-1].sample),
               hi_cycles(k), PS * tbl[k-1].steps);
         chk_i($sformatf("align_%0d", k), misaligned(k), 0);
      end
      chk_i("duty_no_ur", ur_count(1, 4097), 0);
      chk_b("duty_ur_end", ur[4098], 1'b1);
      feed_en = 1'b0;
      s_valid = 1'b0;
      enable  = 1'b0;
      run(1);
      chk_b("duty_stop_aud", audio_out, 1'b0);
      chk_b("duty_stop_busy", busy, 1'b0);

      // priming holds with one sample, starts on the edge after the second
      push_chk(8'h60, 1'b1, "prime_rdy");
      enable = 1'b1;
      mark();
      run(20);
      chk_i("prime_quiet", hi_range(1, 20), 0);
      chk_b("prime_busy", busy, 1'b1);
      s_valid = 1'b1;
      s_data  = 8'hC0;
      run(1);
      s_valid = 1'b0;
      chk_b("prime_a1", audio_out, 1'b0);
      run(2);
      chk_b("prime_a3", audio_out, 1'b0);
      run(1);
      chk_b("prime_a4", audio_out, 1'b1);
      RST_N  = 1'b0;
      enable = 1'b0;
      step();
      chk_b("rst1_busy", busy, 1'b0);
      chk_b("rst1_audio", audio_out, 1'b0);
      chk_b("rst1_ready", s_ready, 1'b1);
      RST_N = 1'b1;
      step();

      // underrun after two queued samples
      push_chk(8'h20, 1'b1, "ur_rdy0");
      push_chk(8'h20, 1'b1, "ur_rdy1");
      enable = 1'b1;
      mark();
      run(2100);
      chk_i("ur_p1", hi_cycles(1), PS * 32);
      chk_i("ur_p2", hi_cycles(2), PS * 32);
      chk_i("ur_p3", hi_cycles(3), PS * 128);
      chk_i("ur_early", ur_count(1, 1025), 0);
      chk_b("ur_pulse2", ur[1026], 1'b1);
      chk_i("ur_gap3", ur_count(1027, 1537), 0);
      chk_b("ur_pulse3", ur[1538], 1'b1);
      chk_i("ur_gap4", ur_count(1539, 2049), 0);
      chk_b("ur_pulse4", ur[2050], 1'b1);
      enable = 1'b0;
      run(1);

      // push lands on the swap tick with 3 queued
      push_chk(8'h10, 1'b1, "sp_rdy0");
      push_chk(8'h30, 1'b1, "sp_rdy1");
      push_chk(8'h50, 1'b1, "sp_rdy2");
      push_chk(8'h70, 1'b1, "sp_rdy3");
      chk_b("sp_full", s_ready, 1'b0);
      enable = 1'b1;
      mark();
      run(513);
      s_valid = 1'b1;
      s_data  = 8'h90;
      run(1);
      s_valid = 1'b0;
      chk_b("sp_count3", s_ready, 1'b1);
      run(2049);
      chk_i("sp_p2", hi_cycles(2), PS * 8'h30);
      chk_i("sp_p3", hi_cycles(3), PS * 8'h50);
      chk_i("sp_p4", hi_cycles(4), PS * 8'h70);
      chk_i("sp_p5", hi_cycles(5), PS * 8'h90);
      chk_i("sp_no_ur", ur_count(1, 2561), 0);
      chk_b("sp_ur_end", ur[2562], 1'b1);

      // stop mid-period, FIFO keeps its two entries, resume
      push_chk(8'hA0, 1'b1, "sr_rdy0");
      push_chk(8'h08, 1'b1, "sr_rdy1");
      repeat (130) step();
      chk_b("sr_pre", audio_out, 1'b1);
      enable = 1'b0;
      step();
      chk_b("sr_audio", audio_out, 1'b0);
      chk_b("sr_busy", busy, 1'b0);
      push_chk(8'h11, 1'b1, "sr_rdy2");
      push_chk(8'h22, 1'b1, "sr_rdy3");
      chk_b("sr_keep2", s_ready, 1'b0);
      enable = 1'b1;
      mark();
      run(515);
      chk_b("sr_prime", aud[3], 1'b0);
      chk_i("sr_first", hi_cycles(1), PS * 8'hA0);

      // reset mid-play discards FIFO
      RST_N  = 1'b0;
      enable = 1'b0;
      step();
      chk_b("rst2_busy", busy, 1'b0);
      chk_b("rst2_audio", audio_out, 1'b0);
      chk_b("rst2_ready", s_ready, 1'b1);
      RST_N = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         push_chk(8'(i + 1), 1'b1, $sformatf("rst2_rdy%0d", i));
      end
      chk_b("rst2_full", s_ready, 1'b0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
